// File: rtl/debounce_scheduler.sv
`default_nettype none
// ============================================================================
// debounce_scheduler : shared-tick multi-channel push-button debouncer with
// clean levels and press/release pulses; long-press via DEBOUNCE_HOLD_EN.
// Revision: 1.0
// ============================================================================
module debounce_scheduler #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 20,
    parameter int HOLD_TICKS   = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_db,
    output logic [CHANNELS-1:0] rise_p,
    output logic [CHANNELS-1:0] fall_p,
`ifdef DEBOUNCE_HOLD_EN
    output logic [CHANNELS-1:0] hold_p,
`endif
    output logic                busy
);

    localparam int PW = ($clog2(TICK_DIV) > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = ($clog2(STABLE_TICKS + 1) > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
    logic                tick;
    logic [CHANNELS-1:0] waiting;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick      = 1'b0;
        if (enable) begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pre_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_q, db_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;

        // A bounce back to the current level outranks a tick in the same cycle.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                ST_ZERO: begin
                    if (sync2_q[i]) begin
                        state_d = ST_WAIT1;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT1: begin
                    if (!sync2_q[i]) begin
                        state_d = ST_ZERO;
                    end else if (tick) begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_d = ST_ONE;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_ONE: begin
                    if (!sync2_q[i]) begin
                        state_d = ST_WAIT0;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT0: begin
                    if (sync2_q[i]) begin
                        state_d = ST_ONE;
                    end else if (tick) begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_d = ST_ZERO;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end
            endcase
            db_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_ZERO;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign btn_db[i]  = db_q;
        assign rise_p[i]  = rise_q;
        assign fall_p[i]  = fall_q;
        assign waiting[i] = (state_q == ST_WAIT1) || (state_q == ST_WAIT0);

`ifdef DEBOUNCE_HOLD_EN
        localparam int HW = ($clog2(HOLD_TICKS) > 1) ? $clog2(HOLD_TICKS) : 1;
        localparam logic [HW-1:0] HOLD_PRE = HW'((HOLD_TICKS > 1) ? HOLD_TICKS - 2 : 0);

        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic          hold_done_q, hold_done_d;
        logic          hold_q, hold_d;

        // Counter lives only while resting in ONE; done flag makes it one pulse per press.
        always_comb begin
            hold_cnt_d  = hold_cnt_q;
            hold_done_d = hold_done_q;
            hold_d      = 1'b0;
            if ((state_q != ST_ONE) || (state_d != ST_ONE)) begin
                hold_cnt_d  = '0;
                hold_done_d = 1'b0;
            end else if (tick && !hold_done_q) begin
                if ((HOLD_TICKS <= 1) || (hold_cnt_q == HOLD_PRE)) begin
                    hold_d      = 1'b1;
                    hold_done_d = 1'b1;
                end
                if (HOLD_TICKS > 1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_cnt_q  <= '0;
                hold_done_q <= 1'b0;
                hold_q      <= 1'b0;
            end else begin
                hold_cnt_q  <= hold_cnt_d;
                hold_done_q <= hold_done_d;
                hold_q      <= hold_d;
            end
        end

        assign hold_p[i] = hold_q;
`endif
    end

`ifndef DEBOUNCE_HOLD_EN
    logic hold_cfg_unused;
    assign hold_cfg_unused = |HOLD_TICKS;
`endif

    assign busy = |waiting;

endmodule
`default_nettype wire

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Multi-channel push-button debounce controller.
- Generates one shared sample tick from a clock prescaler and sequences a per-channel settle counter and 4-state FSM against that tick.
- Emits clean levels plus single-cycle press/release pulses.
- Sits between raw board inputs and downstream control logic.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
TICK_DIV, 100000, clk cycles per sample tick (>=2)
STABLE_TICKS, 20, consecutive stable ticks required to accept a new level (>=1)
HOLD_TICKS, 50, ticks in pressed state before long-press pulse (used only with DEBOUNCE_HOLD_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  tick prescaler run enable
btn_in  input  CHANNELS  raw asynchronous button inputs, active-high
btn_db  output  CHANNELS  debounced level per channel, registered
rise_p  output  CHANNELS  one-clk pulse on accepted 0->1
fall_p  output  CHANNELS  one-clk pulse on accepted 1->0
busy  output  1  high while any channel is in WAIT1 or WAIT0
hold_p  output  CHANNELS  long-press pulse, present only with DEBOUNCE_HOLD_EN

Behaviour:
- Reset (reset_n=0, async) clears:
  - synchronizers, prescaler, settle counters, FSMs (state ZERO);
  - btn_db, rise_p, fall_p, hold_p = 0; busy = 0.
- Synchronizer: 2 flops per channel. sync[i] lags btn_in[i] by 2 clk.
- Prescaler:
  - Width max(1, $clog2(TICK_DIV)). Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for one clk when count==TICK_DIV-1 and enable=1.
  - enable=0: count held, no ticks.
- Settle counter per channel: width max(1, $clog2(STABLE_TICKS+1)). Cleared on every entry to WAIT1/WAIT0.
- FSM per channel:
  - ZERO: sync=1 -> WAIT1.
  - WAIT1: sync=0 -> ZERO (bounce; has priority over a same-cycle tick). Else, on tick: if cnt==STABLE_TICKS-1 -> ONE; otherwise cnt+1.
  - ONE: sync=0 -> WAIT0.
  - WAIT0: sync=1 -> ONE (bounce, priority). Else, on tick: if cnt==STABLE_TICKS-1 -> ZERO; otherwise cnt+1.
- Outputs:
  - btn_db=1 in ONE and WAIT0; btn_db=0 in ZERO and WAIT1. Registered; changes on the same edge as the state.
  - rise_p is high the single clk after the WAIT1->ONE edge, coincident with btn_db rising. fall_p is the same for WAIT0->ZERO.
  - busy = OR over channels of (state==WAIT1 or state==WAIT0). Combinational from state registers.
- Acceptance latency from a stable btn_in edge: 3 + (STABLE_TICKS-1)*TICK_DIV to 3 + STABLE_TICKS*TICK_DIV clk.
- Channels are fully independent. Simultaneous qualifications in one cycle assert the corresponding pulse bits together.
- enable=0 during WAITx: the channel stays in WAITx (no tick) but still returns on a bounce.
- Reset mid-operation aborts all channels. An input still held high afterwards is treated as a fresh press and produces a new rise_p.
- Settle counters never exceed STABLE_TICKS-1; no wrap.

Optional Feature:
- DEBOUNCE_HOLD_EN defined:
  - Adds the hold_p port and a per-channel hold counter, cleared on entry to ONE.
  - The counter increments on each tick while the channel is in ONE.
  - When the counter reaches HOLD_TICKS-1 on a tick, hold_p[i] pulses one clk, exactly once per press. The counter then saturates.
  - Leaving ONE (including to WAIT0) clears the counter.
- Undefined: no hold_p port, no hold logic.

Test Plan:
- Bench parameters: CHANNELS=4, TICK_DIV=4, STABLE_TICKS=3.
- Clean press: btn_in[0] 0->1 and held -> btn_db[0]=1 within 11..15 clk; rise_p[0] high exactly 1 clk; busy high during wait, low after.
- Bounce: btn_in[1] toggled every 3 clk for 30 clk, then held 0 -> btn_db[1] stays 0; no rise_p/fall_p; busy pulses; ends at 0.
- Release: after the clean press, btn_in[0] 1->0 and held -> btn_db[0]=0 within 11..15 clk; fall_p[0] exactly one pulse; rise_p[0] silent.
- Simultaneous: btn_in[0] and btn_in[3] rise on the same clk -> rise_p=4'b1001 in a single cycle; btn_db=4'b1001.
- Reset mid-WAIT1: reset_n low for 2 clk at clk 6 of a press, input held high -> all outputs 0 during reset; rise_p[0] later fires once within 11..15 clk of reset release.
- Enable gating: enable=0, btn_in[2] held high for 100 clk -> btn_db[2]=0, busy=1; enable raised -> btn_db[2]=1 within 8..12 clk. With DEBOUNCE_HOLD_EN and HOLD_TICKS=5: hold_p[2] fires once, 16..20 clk after btn_db[2] rises.
